// File: rtl/mips_debug_unit.sv
// mips_debug_unit: host byte-link debug controller (load, run, step, dump) for the Mips pipeline.
// Optional MIPS_DEBUG_CYCLE_CNT_EN adds a run-cycle counter word after PC in every dump.
module mips_debug_unit #(
  parameter int NB_BITS   = 32,
  parameter int NB_REG    = 5,
  parameter int NB_IADDR  = 10,
  parameter int MEM_DEPTH = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [7:0]          i_rx_data,
  input  logic                i_rx_valid,
  output logic [7:0]          o_tx_data,
  output logic                o_tx_valid,
  input  logic                i_tx_ready,
  output logic                o_debug,
  output logic                o_step,
  input  logic                i_halt,
  output logic                o_instr_we,
  output logic [NB_IADDR-1:0] o_instr_addr,
  output logic [NB_BITS-1:0]  o_instr_data,
  output logic [NB_REG-1:0]   o_reg_addr,
  input  logic [NB_BITS-1:0]  i_reg_data,
  output logic [NB_BITS-1:0]  o_mem_addr,
  input  logic [NB_BITS-1:0]  i_mem_data,
  input  logic [NB_BITS-1:0]  i_pc_debug,
  output logic                o_busy
);
  typedef enum logic [3:0] {
    IDLE, LD_CNT, LD_BYTE, LD_WR, RUN, STEP, SETTLE, RD_ADDR, RD_WAIT, TX_BYTE
  } state_t;
`ifdef MIPS_DEBUG_CYCLE_CNT_EN
  localparam int CC = 1;
`else
  localparam int CC = 0;
`endif
  localparam int NW = 1 + CC + 2**NB_REG + MEM_DEPTH;
  localparam int WW = $clog2(NW);
  localparam int MW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
  localparam logic [WW-1:0] R_BASE = WW'(1 + CC);
  localparam logic [WW-1:0] M_BASE = WW'(1 + CC + 2**NB_REG);
  localparam logic [WW-1:0] W_LAST = WW'(NW - 1);
  localparam logic [MW-1:0] M_LAST = MW'(MEM_DEPTH - 1);
  state_t state, nxt;
  logic [8:0] cnt, k;
  logic [1:0] bidx, tcnt;
  logic [31:0] ld_word, tx_word, word_sel;
  logic [WW-1:0] wd;
  logic [NB_REG-1:0] reg_cnt;
  logic [MW-1:0] mem_cnt;
  logic is_break;
`ifdef MIPS_DEBUG_CYCLE_CNT_EN
  logic [31:0] cyc;
`endif
  assign is_break = i_rx_valid && i_rx_data == 8'h05;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:
        if (i_rx_valid)
          nxt = i_rx_data == 8'h01 ? LD_CNT :
                i_rx_data == 8'h02 ? RUN :
                i_rx_data == 8'h03 ? STEP :
                i_rx_data == 8'h04 ? RD_ADDR : IDLE;
      LD_CNT:  nxt = i_rx_valid ? LD_BYTE : LD_CNT;
      LD_BYTE: nxt = i_rx_valid && bidx == 2'd3 ? LD_WR : LD_BYTE;
      LD_WR:   nxt = k == cnt - 9'd1 ? IDLE : LD_BYTE;
      RUN:     nxt = i_halt || is_break ? RD_ADDR : RUN;
      STEP:    nxt = SETTLE;
      SETTLE:  nxt = RD_ADDR;
      RD_ADDR: nxt = RD_WAIT;
      RD_WAIT: nxt = TX_BYTE;
      TX_BYTE: nxt = i_tx_ready && tcnt == 2'd3 ? (wd == W_LAST ? IDLE : RD_ADDR) : TX_BYTE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    word_sel = 32'(i_mem_data);
    if (wd < M_BASE) word_sel = 32'(i_reg_data);
`ifdef MIPS_DEBUG_CYCLE_CNT_EN
    if (wd == WW'(1)) word_sel = cyc;
`endif
    if (wd == '0) word_sel = 32'(i_pc_debug);
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      cnt <= '0;
      k <= '0;
      bidx <= '0;
      tcnt <= '0;
      ld_word <= '0;
      tx_word <= '0;
      wd <= '0;
      reg_cnt <= '0;
      mem_cnt <= '0;
`ifdef MIPS_DEBUG_CYCLE_CNT_EN
      cyc <= '0;
`endif
    end else begin
      if (nxt == RD_ADDR && state != TX_BYTE) begin
        wd <= '0;
        reg_cnt <= '0;
        mem_cnt <= '0;
      end
`ifdef MIPS_DEBUG_CYCLE_CNT_EN
      if (state == IDLE && nxt == LD_CNT) cyc <= '0;
      if (state == RUN || state == STEP) cyc <= cyc + 32'd1;
`endif
      case (state)
        LD_CNT:
          if (i_rx_valid) begin
            cnt <= {i_rx_data == 8'h00, i_rx_data};
            k <= '0;
            bidx <= '0;
          end
        LD_BYTE, LD_WR: begin
          if (state == LD_WR) k <= k + 9'd1;
          if (i_rx_valid) begin
            ld_word <= {i_rx_data, ld_word[31:8]};
            bidx <= bidx + 2'd1;
          end
        end
        RD_WAIT: begin
          tx_word <= word_sel;
          tcnt <= '0;
        end
        TX_BYTE:
          if (i_tx_ready) begin
            tx_word <= {8'h00, tx_word[31:8]};
            tcnt <= tcnt + 2'd1;
            if (tcnt == 2'd3 && wd != W_LAST) begin
              wd <= wd + WW'(1);
              if (wd >= R_BASE && wd < M_BASE && reg_cnt != '1) reg_cnt <= reg_cnt + 1'b1;
              if (wd >= M_BASE && mem_cnt != M_LAST) mem_cnt <= mem_cnt + 1'b1;
            end
          end
        default: ;
      endcase
    end
  always_comb begin
    o_debug = state != RUN;
    o_step = state == STEP;
    o_busy = state != IDLE;
    o_instr_we = state == LD_WR;
    o_instr_addr = NB_IADDR'(k);
    o_instr_data = NB_BITS'(ld_word);
    o_reg_addr = reg_cnt;
    o_mem_addr = NB_BITS'({mem_cnt, 2'b00});
    o_tx_valid = state == TX_BYTE;
    o_tx_data = tx_word[7:0];
  end
endmodule

// File: tb/tb_mips_debug_unit.sv
// tb_mips_debug_unit: directed table plus dump/step/run/reset sequences for mips_debug_unit.
module tb_mips_debug_unit;
`ifdef MIPS_DEBUG_CYCLE_CNT_EN
  localparam int CC = 1;
`else
  localparam int CC = 0;
`endif
  localparam int NWORDS = 1 + CC + 32 + 16;
  logic        i_clk = 0, i_rst = 1;
  logic [7:0]  i_rx_data = 0;
  logic        i_rx_valid = 0;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready = 1;
  logic        o_debug, o_step, i_halt = 0, o_instr_we, o_busy;
  logic [9:0]  o_instr_addr;
  logic [31:0] o_instr_data, i_reg_data, o_mem_addr, i_mem_data, i_pc_debug;
  logic [4:0]  o_reg_addr;
  int n_chk = 0, n_fail = 0;
  int we_cnt = 0, step_cnt = 0, low_cnt = 0, stall_err = 0;
  bit rand_ready = 0, stall_prev = 0;
  logic [7:0] stall_data;
  logic [7:0] rxq[$];
  logic [31:0] cyc_exp;

  mips_debug_unit dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
    .o_debug(o_debug), .o_step(o_step), .i_halt(i_halt), .o_instr_we(o_instr_we),
    .o_instr_addr(o_instr_addr), .o_instr_data(o_instr_data), .o_reg_addr(o_reg_addr),
    .i_reg_data(i_reg_data), .o_mem_addr(o_mem_addr), .i_mem_data(i_mem_data),
    .i_pc_debug(i_pc_debug), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;
  assign i_pc_debug = 32'h40;
  assign i_reg_data = 32'(o_reg_addr);
  assign i_mem_data = 32'h100 + (o_mem_addr >> 2);

  always @(negedge i_clk) begin
    i_tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (o_instr_we) we_cnt++;
    if (o_step) step_cnt++;
    if (!o_debug) low_cnt++;
  end

  always @(posedge i_clk) begin
    if (stall_prev && (!o_tx_valid || o_tx_data != stall_data)) stall_err++;
    stall_prev = o_tx_valid && !i_tx_ready;
    stall_data = o_tx_data;
    if (o_tx_valid && i_tx_ready) rxq.push_back(o_tx_data);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge i_clk);
    i_rx_valid = 1;
    i_rx_data = b;
    @(negedge i_clk);
    i_rx_valid = 0;
  endtask

  task automatic wait_idle(input string name);
    int i = 0;
    while (o_busy && i < 5000) begin
      @(negedge i_clk);
      i++;
    end
    chk({name, " done"}, 32'(o_busy), 32'd0);
  endtask

  task automatic check_dump(input string name, input logic [31:0] cyc);
    logic [31:0] w, e;
    chk({name, " length"}, 32'(rxq.size()), 32'(4 * NWORDS));
    if (rxq.size() == 4 * NWORDS)
      for (int i = 0; i < NWORDS; i++) begin
        w = {rxq[4*i+3], rxq[4*i+2], rxq[4*i+1], rxq[4*i]};
        e = i == 0 ? 32'h40 : (CC == 1 && i == 1) ? cyc :
            i < 1 + CC + 32 ? 32'(i - 1 - CC) : 32'h100 + 32'(i - 33 - CC);
        chk($sformatf("%s word %0d", name, i), w, e);
      end
    chk({name, " tx stable when stalled"}, 32'(stall_err), 32'd0);
  endtask

  typedef struct {
    logic v; logic [7:0] d;
    logic we; logic [9:0] addr; logic [31:0] data; logic busy;
  } vec_t;
  vec_t tbl[14];

  initial begin
    tbl[0]  = '{1'b1, 8'h01, 1'b0, 10'd0, 32'h0, 1'b1};
    tbl[1]  = '{1'b1, 8'h02, 1'b0, 10'd0, 32'h0, 1'b1};
    tbl[2]  = '{1'b1, 8'h78, 1'b0, 10'd0, 32'h0, 1'b1};
    tbl[3]  = '{1'b1, 8'h56, 1'b0, 10'd0, 32'h0, 1'b1};
    tbl[4]  = '{1'b1, 8'h34, 1'b0, 10'd0, 32'h0, 1'b1};
    tbl[5]  = '{1'b1, 8'h12, 1'b1, 10'd0, 32'h12345678, 1'b1};
    tbl[6]  = '{1'b1, 8'hEF, 1'b0, 10'd0, 32'h0, 1'b1};
    tbl[7]  = '{1'b1, 8'hBE, 1'b0, 10'd0, 32'h0, 1'b1};
    tbl[8]  = '{1'b1, 8'hAD, 1'b0, 10'd0, 32'h0, 1'b1};
    tbl[9]  = '{1'b1, 8'hDE, 1'b1, 10'd1, 32'hDEADBEEF, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 10'd0, 32'h0, 1'b0};
    tbl[11] = '{1'b1, 8'h09, 1'b0, 10'd0, 32'h0, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 10'd0, 32'h0, 1'b0};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 10'd0, 32'h0, 1'b0};
    #1;
    chk("reset debug", 32'(o_debug), 32'd1);
    chk("reset busy", 32'(o_busy), 32'd0);
    chk("reset tx_valid", 32'(o_tx_valid), 32'd0);
    chk("reset step", 32'(o_step), 32'd0);
    repeat (2) @(negedge i_clk);
    i_rst = 0;
    we_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge i_clk);
      i_rx_valid = tbl[i].v;
      i_rx_data = tbl[i].d;
      @(posedge i_clk);
      #1;
      chk($sformatf("vec %0d we", i), 32'(o_instr_we), 32'(tbl[i].we));
      chk($sformatf("vec %0d busy", i), 32'(o_busy), 32'(tbl[i].busy));
      chk($sformatf("vec %0d debug", i), 32'(o_debug), 32'd1);
      if (tbl[i].we) begin
        chk($sformatf("vec %0d addr", i), 32'(o_instr_addr), 32'(tbl[i].addr));
        chk($sformatf("vec %0d data", i), o_instr_data, tbl[i].data);
      end
    end
    @(negedge i_clk);
    i_rx_valid = 0;
    chk("load strobe count", 32'(we_cnt), 32'd2);
    cyc_exp = 0;
    // plain dump with a randomly stalling transmitter
    rand_ready = 1;
    rxq.delete();
    stall_err = 0;
    send(8'h04);
    wait_idle("dump");
    check_dump("dump", cyc_exp);
    // single step
    rxq.delete();
    step_cnt = 0;
    low_cnt = 0;
    send(8'h03);
    wait_idle("step");
    cyc_exp = cyc_exp + 1;
    chk("step pulses", 32'(step_cnt), 32'd1);
    chk("step debug low cycles", 32'(low_cnt), 32'd0);
    check_dump("step", cyc_exp);
    // run stopped by halt during the 10th running cycle
    rxq.delete();
    low_cnt = 0;
    send(8'h02);
    repeat (9) @(negedge i_clk);
    i_halt = 1;
    @(negedge i_clk);
    i_halt = 0;
    wait_idle("run halt");
    cyc_exp = cyc_exp + 10;
    chk("run halt debug low cycles", 32'(low_cnt), 32'd10);
    check_dump("run halt", cyc_exp);
    // run, non-break byte ignored, then break
    rxq.delete();
    low_cnt = 0;
    send(8'h02);
    send(8'h07);
    chk("run ignores 0x07", 32'(o_debug), 32'd0);
    send(8'h05);
    wait_idle("run break");
    cyc_exp = cyc_exp + 4;
    chk("run break debug low cycles", 32'(low_cnt), 32'd4);
    check_dump("run break", cyc_exp);
    // reset in the middle of a LOAD word
    rand_ready = 0;
    we_cnt = 0;
    send(8'h01);
    send(8'h01);
    send(8'hAA);
    send(8'hBB);
    #2 i_rst = 1;
    #1;
    chk("mid reset busy", 32'(o_busy), 32'd0);
    chk("mid reset debug", 32'(o_debug), 32'd1);
    chk("mid reset we", 32'(o_instr_we), 32'd0);
    chk("mid reset instr_data", o_instr_data, 32'd0);
    chk("mid reset instr_addr", 32'(o_instr_addr), 32'd0);
    chk("mid reset tx_valid", 32'(o_tx_valid), 32'd0);
    chk("mid reset reg_addr", 32'(o_reg_addr), 32'd0);
    chk("mid reset mem_addr", o_mem_addr, 32'd0);
    @(negedge i_clk);
    i_rst = 0;
    send(8'hCC);
    send(8'hDD);
    repeat (3) @(negedge i_clk);
    chk("no write after reset", 32'(we_cnt), 32'd0);
    chk("idle after reset", 32'(o_busy), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
